multi_service_unit: RTL and testbench



---
 rtl/multi_service_unit_pkg.sv | 17 +
 rtl/service_prio_enc.sv | 15 +
 rtl/multi_service_unit.sv | 101 ++++++++++
 tb/tb_multi_service_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/multi_service_unit_pkg.sv
// multi_service_unit_pkg: register map, FSM encoding and ACK layout for the service unit
package multi_service_unit_pkg;
    localparam logic [2:0] REG_ENABLE   = 3'd0;
    localparam logic [2:0] REG_PENDING  = 3'd1;
    localparam logic [2:0] REG_PEND_SET = 3'd2;
    localparam logic [2:0] REG_PEND_CLR = 3'd3;
    localparam logic [2:0] REG_MODE     = 3'd4;
    localparam logic [2:0] REG_ACK      = 3'd5;
    localparam logic [2:0] REG_EOI      = 3'd6;
    localparam logic [2:0] REG_STATUS   = 3'd7;
    localparam int ACK_VALID_BIT = 31;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LATCHED = 2'd1,
        ST_SERVING = 2'd2
    } state_t;
endpackage

// File: rtl/service_prio_enc.sv
// service_prio_enc: combinational highest-set-bit encoder
module service_prio_enc #(
    parameter int N    = 32,
    parameter int ID_W = 5
) (
    input  logic [N-1:0]    req,
    output logic [ID_W-1:0] id,
    output logic            any
);
    always_comb begin
        id = '0;
        for (int k = 0; k < N; k++) id = req[k] ? ID_W'(k) : id;
    end
    assign any = |req;
endmodule

// File: rtl/multi_service_unit.sv
// multi_service_unit: APB interrupt/event service controller with claim/complete handshake
module multi_service_unit
    import multi_service_unit_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NUM_SRC        = 32
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [NUM_SRC-1:0]        signal_i,
    input  logic                      core_sleeping_i,
    output logic                      irq_o
);
    localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] r_enable, r_pending, r_mode, r_sig_q;
    logic [ID_W-1:0]    r_id;
    state_t             r_state;
    logic               r_irq;

    logic               w_wr, w_rd, w_ack, w_eoi, w_any, w_grant, w_unused;
    logic [2:0]         w_sel;
    logic [NUM_SRC-1:0] w_wdat, w_event, w_clr_arb, w_pend_nxt;
    logic [ID_W-1:0]    w_win_id;
    state_t             w_state_nxt;
    logic [31:0]        w_rdata;

    assign w_wr     = PSEL & PENABLE & PWRITE;
    assign w_rd     = PSEL & PENABLE & ~PWRITE;
    assign w_sel    = PADDR[4:2];
    assign w_wdat   = PWDATA[NUM_SRC-1:0];
    assign w_ack    = w_rd && w_sel == REG_ACK;
    assign w_eoi    = w_wr && w_sel == REG_EOI;
    assign w_unused = ^{PADDR, PWDATA};

    assign w_event = r_enable & ((r_mode & signal_i & ~r_sig_q) | (~r_mode & signal_i));

    service_prio_enc #(.N(NUM_SRC), .ID_W(ID_W)) u_prio (
        .req (r_pending & r_enable),
        .id  (w_win_id),
        .any (w_any)
    );

    assign w_grant   = (r_state == ST_IDLE) && w_any;
    assign w_clr_arb = w_grant ? (NUM_SRC'(1) << w_win_id) : '0;

    // Events are OR-ed last so a source re-firing while being claimed stays pending
    assign w_pend_nxt = ((((w_wr && w_sel == REG_PENDING) ? w_wdat : r_pending)
                        | ((w_wr && w_sel == REG_PEND_SET) ? w_wdat : '0))
                        & ~((w_wr && w_sel == REG_PEND_CLR) ? w_wdat : '0)
                        & ~w_clr_arb) | w_event;

    assign w_state_nxt = w_grant ? ST_LATCHED :
                         (r_state == ST_LATCHED && w_ack) ? ST_SERVING :
                         (r_state == ST_SERVING && w_eoi) ? ST_IDLE : r_state;

    always_comb begin
        case (w_sel)
            REG_ENABLE:  w_rdata = 32'(r_enable);
            REG_PENDING: w_rdata = 32'(r_pending);
            REG_MODE:    w_rdata = 32'(r_mode);
            REG_ACK:     w_rdata = (r_state == ST_LATCHED) ? ((32'(1) << ACK_VALID_BIT) | 32'(r_id)) : '0;
            REG_STATUS:  w_rdata = 32'(r_state) | (32'(r_id) << 8);
            default:     w_rdata = '0;
        endcase
    end

    assign PRDATA  = w_rd ? w_rdata : '0;
    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;
    assign irq_o   = r_irq;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_enable  <= '0;
            r_pending <= '0;
            r_mode    <= '0;
            r_sig_q   <= '0;
            r_id      <= '0;
            r_state   <= ST_IDLE;
            r_irq     <= 1'b0;
        end else begin
            r_sig_q   <= signal_i;
            r_pending <= w_pend_nxt;
            r_state   <= w_state_nxt;
            // Sleeping core is re-woken while its service is still open
            r_irq     <= (w_state_nxt == ST_LATCHED) | ((w_state_nxt == ST_SERVING) & core_sleeping_i);
            if (w_grant) r_id <= w_win_id;
            if (w_wr && w_sel == REG_ENABLE) r_enable <= w_wdat;
            if (w_wr && w_sel == REG_MODE) r_mode <= w_wdat;
        end
    end
endmodule

// File: tb/tb_multi_service_unit.sv
// tb_multi_service_unit: directed APB stimulus with a read-data scoreboard for multi_service_unit
module tb_multi_service_unit;
    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [11:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic        PWRITE = 1'b0, PENABLE = 1'b0, psel = 1'b0, tgt = 1'b0;
    logic        core_sleeping = 1'b0;
    logic [31:0] sig = '0;
    logic [31:0] PRDATA, prdata5;
    logic        PREADY, PSLVERR, irq, pready5, pslverr5, irq5;
    logic        sel_m, sel_5;
    exp_t        sb[$];
    exp_t        e;
    int          checks = 0, errors = 0;

    assign sel_m = psel & ~tgt;
    assign sel_5 = psel & tgt;

    always #5 HCLK = ~HCLK;

    multi_service_unit #(.APB_ADDR_WIDTH(12), .NUM_SRC(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
        .PSEL(sel_m), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .signal_i(sig), .core_sleeping_i(core_sleeping), .irq_o(irq)
    );

    multi_service_unit #(.APB_ADDR_WIDTH(12), .NUM_SRC(5)) dut5 (
        .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
        .PSEL(sel_5), .PENABLE(PENABLE), .PRDATA(prdata5), .PREADY(pready5), .PSLVERR(pslverr5),
        .signal_i(5'b0), .core_sleeping_i(1'b0), .irq_o(irq5)
    );

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        psel = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
        tick(1);
        PENABLE = 1'b1;
        tick(1);
        psel = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, input string n, input logic [31:0] x);
        psel = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
        tick(1);
        sb.push_back('{name: n, val: x});
        PENABLE = 1'b1;
        tick(1);
        psel = 1'b0; PENABLE = 1'b0;
    endtask

    always @(negedge HCLK) begin
        if (psel && PENABLE && !PWRITE) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read got %h expected none", tgt ? prdata5 : PRDATA);
            end else begin
                e = sb.pop_front();
                chk(e.name, tgt ? prdata5 : PRDATA, e.val);
            end
        end
    end

    initial begin
        tick(3);
        chk("reset_irq", 32'(irq), 32'd0);
        chk("pready", 32'(PREADY), 32'd1);
        chk("pslverr", 32'(PSLVERR), 32'd0);
        HRESETn = 1'b1;
        tick(1);
        rd(12'h1C, "reset_status", 32'h0);
        rd(12'h00, "reset_enable", 32'h0);
        rd(12'h04, "reset_pending", 32'h0);

        // level pulse on sources 8 and 4, highest index claimed first
        wr(12'h00, 32'hFFFF_FFFF);
        sig = 32'h0000_0110;
        tick(1);
        sig = 32'h0;
        chk("t1_irq_early", 32'(irq), 32'd0);
        tick(1);
        chk("t1_irq_rise", 32'(irq), 32'd1);
        rd(12'h14, "t1_ack8", 32'h8000_0008);
        chk("t1_irq_fall", 32'(irq), 32'd0);
        rd(12'h1C, "t1_status_serving", 32'h0000_0802);
        wr(12'h18, 32'h0);
        rd(12'h14, "t1_ack4", 32'h8000_0004);
        rd(12'h04, "t1_pending", 32'h0);
        wr(12'h18, 32'h0);

        // edge mode on source 3: one claim for a long high level
        wr(12'h00, 32'h8);
        wr(12'h10, 32'h8);
        sig = 32'h8;
        tick(4);
        rd(12'h04, "t2_edge_pending", 32'h0);
        tick(4);
        sig = 32'h0;
        rd(12'h14, "t2_edge_ack", 32'h8000_0003);
        wr(12'h18, 32'h0);
        tick(2);
        rd(12'h1C, "t2_edge_idle", 32'h0000_0300);
        // level mode re-pends while high
        wr(12'h10, 32'h0);
        sig = 32'h8;
        tick(3);
        rd(12'h04, "t2_level_pending", 32'h8);
        sig = 32'h0;
        rd(12'h14, "t2_level_ack1", 32'h8000_0003);
        wr(12'h18, 32'h0);
        rd(12'h14, "t2_level_ack2", 32'h8000_0003);
        wr(12'h18, 32'h0);
        rd(12'h04, "t2_level_pend0", 32'h0);

        // set/clear pending with masking
        wr(12'h00, 32'h0);
        wr(12'h08, 32'h5);
        wr(12'h0C, 32'h1);
        rd(12'h04, "t3_pending", 32'h4);
        rd(12'h08, "t3_pendset_read", 32'h0);
        chk("t3_masked_irq", 32'(irq), 32'd0);
        wr(12'h00, 32'h4);
        rd(12'h14, "t3_ack2", 32'h8000_0002);
        wr(12'h18, 32'h0);

        // ACK in IDLE, EOI in LATCHED
        rd(12'h14, "t4_ack_idle", 32'h0);
        rd(12'h1C, "t4_status_idle", 32'h0000_0200);
        wr(12'h00, 32'h1);
        wr(12'h08, 32'h1);
        wr(12'h18, 32'h0);
        rd(12'h1C, "t4_status_latched", 32'h0000_0001);
        chk("t4_irq_latched", 32'(irq), 32'd1);
        rd(12'h14, "t4_ack0", 32'h8000_0000);
        wr(12'h18, 32'h0);

        // source 7 re-fires in its arbitration cycle
        wr(12'h00, 32'h80);
        sig = 32'h80;
        tick(2);
        sig = 32'h0;
        rd(12'h04, "t5_pending", 32'h80);
        rd(12'h14, "t5_ack7a", 32'h8000_0007);
        wr(12'h18, 32'h0);
        rd(12'h14, "t5_ack7b", 32'h8000_0007);
        rd(12'h04, "t5_pending0", 32'h0);
        wr(12'h18, 32'h0);

        // sleeping core in SERVING, then asynchronous reset
        wr(12'h00, 32'h1);
        wr(12'h08, 32'h1);
        rd(12'h14, "t6_ack0", 32'h8000_0000);
        core_sleeping = 1'b1;
        tick(1);
        chk("t6_wake_irq", 32'(irq), 32'd1);
        rd(12'h1C, "t6_status_serving", 32'h0000_0002);
        #1 HRESETn = 1'b0;
        #1 chk("t6_rst_irq", 32'(irq), 32'd0);
        sb.push_back('{name: "t6_rst_status", val: 32'h0});
        psel = 1'b1; PWRITE = 1'b0; PADDR = 12'h1C; PENABLE = 1'b1;
        @(negedge HCLK);
        #1;
        psel = 1'b0; PENABLE = 1'b0; core_sleeping = 1'b0;
        tick(1);
        HRESETn = 1'b1;
        tick(1);
        rd(12'h00, "t6_enable_cleared", 32'h0);

        // narrow build masks upper bits
        tgt = 1'b1;
        wr(12'h04, 32'hFFFF_FFFF);
        rd(12'h04, "t6_narrow_pending", 32'h0000_001F);
        tgt = 1'b0;

        tick(2);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left got %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
